// File: rtl/dldo_adaptive_ctrl_if.sv
// dldo_adaptive_ctrl_if: comparator/test-load inputs and switch-array outputs of the LDO controller
interface dldo_adaptive_ctrl_if #(
  parameter int ARRSZ = 32,
  parameter int CNT_W = 6
);
  logic             mode;
  logic             ctrl_in;
  logic [CNT_W-1:0] std_pt_in_cnt;
  logic [ARRSZ-1:0] ctrl_word;
  logic [CNT_W-1:0] ctrl_word_cnt;
  logic             locked;
  logic             sat_hi;
  logic             sat_lo;
  modport master (
    output mode, ctrl_in, std_pt_in_cnt,
    input  ctrl_word, ctrl_word_cnt, locked, sat_hi, sat_lo
  );
  modport slave (
    input  mode, ctrl_in, std_pt_in_cnt,
    output ctrl_word, ctrl_word_cnt, locked, sat_hi, sat_lo
  );
endinterface

// File: rtl/dldo_adaptive_ctrl.sv
// dldo_adaptive_ctrl: adaptive-step thermometer power-switch controller with divider, lock and saturation flags
module dldo_adaptive_ctrl #(
  parameter int ARRSZ    = 32,
  parameter int CNT_W    = 6,
  parameter int RST_CNT  = 1,
  parameter int STEP_MAX = 4,
  parameter int DIV      = 1,
  parameter int LOCK_N   = 4
) (
  input logic           clk,
  input logic           reset,
  dldo_adaptive_ctrl_if.slave bus
);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int REV_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] ARR_C  = CNT_W'(ARRSZ);
  localparam logic [CNT_W:0]   ARR_X  = (CNT_W+1)'(ARRSZ);
  localparam logic [CNT_W-1:0] RST_C  = CNT_W'(RST_CNT);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_MAX);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(STEP_MAX / 2);
  localparam logic [DIV_W-1:0] DIV_L  = DIV_W'(DIV - 1);
  localparam logic [REV_W-1:0] LOCK_C = REV_W'(LOCK_N);
  logic [CNT_W-1:0] cnt, step, cnt_d, up_c, dn_c, std_c, step_nxt;
  logic [CNT_W:0]   up_x;
  logic [DIV_W-1:0] div;
  logic [REV_W-1:0] rev_cnt, rev_nxt;
  logic [ARRSZ-1:0] word;
  logic             prev_dir, first, locked, tick, same;
  always_comb begin
    tick     = div == DIV_L;
    up_x     = {1'b0, cnt} + {1'b0, step};
    up_c     = up_x > ARR_X ? ARR_C : up_x[CNT_W-1:0];
    dn_c     = cnt < step ? '0 : cnt - step;
    std_c    = bus.std_pt_in_cnt > ARR_C ? ARR_C : bus.std_pt_in_cnt;
    same     = bus.ctrl_in == prev_dir;
    step_nxt = same ? (step >= HALF_C ? STEP_C : step << 1) : (step == 1 ? step : step >> 1);
    // Unit-step reversals accumulate toward lock; any larger reversal or same-direction move restarts the count
    rev_nxt  = same || step != 1 ? '0 : (rev_cnt == LOCK_C ? rev_cnt : rev_cnt + 1'b1);
    cnt_d    = reset ? RST_C : !bus.mode ? std_c : !tick ? cnt : bus.ctrl_in ? dn_c : up_c;
  end
  always_ff @(posedge clk) begin
    cnt  <= cnt_d;
    word <= ~({ARRSZ{1'b1}} << cnt_d);
    if (reset) begin
      step     <= STEP_C;
      prev_dir <= 1'b0;
      first    <= 1'b1;
      rev_cnt  <= '0;
      div      <= '0;
      locked   <= 1'b0;
    end else if (!bus.mode) begin
      step    <= STEP_C;
      first   <= 1'b1;
      rev_cnt <= '0;
      div     <= '0;
      locked  <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        prev_dir <= bus.ctrl_in;
        first    <= 1'b0;
        if (!first) begin
          step    <= step_nxt;
          rev_cnt <= rev_nxt;
          locked  <= rev_nxt == LOCK_C;
        end
      end
    end
  end
  assign bus.ctrl_word     = word;
  assign bus.ctrl_word_cnt = cnt;
  assign bus.locked        = locked;
  assign bus.sat_hi        = cnt == ARR_C;
  assign bus.sat_lo        = cnt == '0;
endmodule

// File: tb/tb_dldo_adaptive_ctrl.sv
// tb_dldo_adaptive_ctrl: table-driven check of the default controller plus a divider sequence on a DIV=3 copy
module tb_dldo_adaptive_ctrl;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dldo_adaptive_ctrl_if #(.ARRSZ(32), .CNT_W(6)) bus0 ();
  dldo_adaptive_ctrl_if #(.ARRSZ(32), .CNT_W(6)) bus1 ();
  dldo_adaptive_ctrl u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  dldo_adaptive_ctrl #(.DIV(3)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  typedef struct {
    logic       rst;
    logic       mode;
    logic       ci;
    logic [5:0] std;
    int         cnt;
    logic       lk;
    logic       hi;
    logic       lo;
  } vec_t;
  vec_t vecs[$];
  task automatic add(logic rst, logic mode, logic ci, logic [5:0] std, int cnt, logic lk, logic hi, logic lo);
    vec_t v;
    v.rst = rst; v.mode = mode; v.ci = ci; v.std = std; v.cnt = cnt; v.lk = lk; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] thermo(int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n && i < 32; i++) w[i] = 1'b1;
    return w;
  endfunction
  task automatic step1(int cnt, string name);
    @(posedge clk);
    #1;
    chk({name, "_cnt"}, 32'(bus1.ctrl_word_cnt), cnt);
    chk({name, "_word"}, bus1.ctrl_word, thermo(cnt));
  endtask
  initial begin
    bus0.mode = 0; bus0.ctrl_in = 0; bus0.std_pt_in_cnt = 0;
    bus1.mode = 0; bus1.ctrl_in = 0; bus1.std_pt_in_cnt = 0;
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 5, 5, 0, 0, 0);
    add(0, 0, 0, 40, 32, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 5, 0, 0, 0);
    add(0, 1, 0, 0, 9, 0, 0, 0);
    add(0, 1, 0, 0, 13, 0, 0, 0);
    add(0, 1, 0, 0, 17, 0, 0, 0);
    add(0, 1, 1, 0, 13, 0, 0, 0);
    add(0, 1, 0, 0, 15, 0, 0, 0);
    add(0, 1, 1, 0, 14, 0, 0, 0);
    add(0, 1, 0, 0, 15, 0, 0, 0);
    add(0, 1, 1, 0, 14, 0, 0, 0);
    add(0, 1, 0, 0, 15, 1, 0, 0);
    add(0, 1, 0, 0, 16, 0, 0, 0);
    add(0, 1, 0, 0, 18, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 2, 2, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 30, 30, 0, 0, 0);
    add(0, 1, 0, 0, 32, 0, 1, 0);
    add(0, 1, 0, 0, 32, 0, 1, 0);
    add(0, 1, 1, 0, 28, 0, 0, 0);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus0.mode = vecs[i].mode;
      bus0.ctrl_in = vecs[i].ci;
      bus0.std_pt_in_cnt = vecs[i].std;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), 32'(bus0.ctrl_word_cnt), vecs[i].cnt);
      chk($sformatf("v%0d_word", i), bus0.ctrl_word, thermo(vecs[i].cnt));
      chk($sformatf("v%0d_locked", i), 32'(bus0.locked), 32'(vecs[i].lk));
      chk($sformatf("v%0d_sat_hi", i), 32'(bus0.sat_hi), 32'(vecs[i].hi));
      chk($sformatf("v%0d_sat_lo", i), 32'(bus0.sat_lo), 32'(vecs[i].lo));
    end
    reset = 0;
    bus1.mode = 0; bus1.std_pt_in_cnt = 10;
    step1(10, "div_load");
    bus1.mode = 1; bus1.ctrl_in = 0;
    step1(10, "div_p1");
    step1(10, "div_p2");
    step1(14, "div_t1");
    step1(14, "div_p4");
    step1(14, "div_p5");
    step1(18, "div_t2");
    step1(18, "div_p7");
    bus1.mode = 0; bus1.std_pt_in_cnt = 18;
    step1(18, "div_drop");
    bus1.mode = 1;
    step1(18, "div_r1");
    step1(18, "div_r2");
    step1(22, "div_rt");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
